uart_package_tx: RTL

UART_PACKAGE_TX -- requirements
Module: uart_package_tx

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_package_tx.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, field layout and FSM encoding.
// Used by both the package transmitter and the matching receiver.
package uart_pkg;

  // Default serial timing and frame payload size
  localparam int UART_CLKS_PER_BIT = 100;
  localparam int UART_PACKAGE_SIZE = 40;

  // Counter widths: clocks within a bit, bit position within the payload
  localparam int CNT_W = 8;
  localparam int IDX_W = 6;

  // Payload field layout (LSB-first on the line)
  localparam int SHAPE_LSB = 0;
  localparam int SHAPE_W   = 12;
  localparam int REG_LSB   = 12;
  localparam int REG_W     = 12;
  localparam int DATA_LSB  = 24;
  localparam int DATA_W    = 12;
  localparam int PAD_W     = 4;

  // Line-level FSM states, encoding shared with the receiver
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Assemble the payload word; the top pad bits always go out as zero
  function automatic logic [UART_PACKAGE_SIZE-1:0] pack_package(
    input logic [SHAPE_W-1:0] shape_addr,
    input logic [REG_W-1:0]   reg_addr,
    input logic [DATA_W-1:0]  data
  );
    return {{PAD_W{1'b0}}, data, reg_addr, shape_addr};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: strobes bit_end on the last clock of every bit period
// while enabled. Counter returns to zero on every bit boundary and whenever
// it is idle or restarted, so each new frame starts from a clean bit phase.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic bit_end
);

  logic [CNT_W-1:0] clk_cnt_reg;

  assign bit_end = enable && (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Count clocks within the current bit; wrap to zero at each bit end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_reg <= '0;
    end else if (restart || !enable || bit_end) begin
      clk_cnt_reg <= '0;
    end else begin
      clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_package_tx.sv
// UART package transmitter: accepts a 36-bit package (three 12-bit fields)
// into a one-entry holding register and sends it as a 1-start / N-data /
// 1-stop frame, LSB first. A package accepted during a frame is sent
// immediately after the current stop bit with no idle gap.
module uart_package_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PACKAGE_SIZE = UART_PACKAGE_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SHAPE_W-1:0] shape_addr,
  input  logic [REG_W-1:0]   reg_addr,
  input  logic [DATA_W-1:0]  data,
  output logic               Serial_output,
  output logic               tx_busy,
  output logic               tx_done
);

  uart_state_e             state_reg;
  uart_state_e             state_next;
  logic                    hold_full_reg;
  logic [PACKAGE_SIZE-1:0] hold_reg;
  logic [PACKAGE_SIZE-1:0] shift_reg;
  logic [PACKAGE_SIZE-1:0] shift_next;
  logic [IDX_W-1:0]        bit_index_reg;
  logic [IDX_W-1:0]        bit_index_next;
  logic                    serial_reg;
  logic                    serial_next;
  logic                    tx_done_reg;
  logic                    tx_done_next;
  logic                    bit_end;
  logic                    load;
  logic                    accept;
  logic                    last_bit;

  // Ready depends only on the holding register, never on in_valid
  assign in_ready      = !hold_full_reg;
  assign accept        = in_valid && !hold_full_reg;
  assign last_bit      = (bit_index_reg == IDX_W'(PACKAGE_SIZE - 1));
  assign tx_busy       = (state_reg != ST_IDLE);
  assign Serial_output = serial_reg;
  assign tx_done       = tx_done_reg;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state_reg != ST_IDLE),
    .restart (load),
    .bit_end (bit_end)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: advance on bit boundaries, chain straight into the next frame
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (hold_full_reg) state_next = ST_START;
      ST_START: if (bit_end) state_next = ST_DATA;
      ST_DATA:  if (bit_end && last_bit) state_next = ST_STOP;
      ST_STOP:  if (bit_end) state_next = hold_full_reg ? ST_START : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: shift-register load, bit index, done strobe and next line level
  always_comb begin
    load           = 1'b0;
    shift_next     = shift_reg;
    bit_index_next = bit_index_reg;
    tx_done_next   = 1'b0;
    serial_next    = 1'b1;
    case (state_reg)
      ST_IDLE: load = hold_full_reg;
      ST_DATA: begin
        if (bit_end) begin
          bit_index_next = last_bit ? '0 : bit_index_reg + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          tx_done_next = 1'b1;
          load         = hold_full_reg;
        end
      end
      default: ;
    endcase
    if (load) begin
      shift_next     = hold_reg;
      bit_index_next = '0;
    end
    // Line level is computed for the state being entered so the flop is never late
    case (state_next)
      ST_START: serial_next = 1'b0;
      ST_DATA:  serial_next = shift_next[bit_index_next];
      default:  serial_next = 1'b1;
    endcase
  end

  // Holding register, shift register and bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full_reg <= 1'b0;
      hold_reg      <= '0;
      shift_reg     <= '0;
      bit_index_reg <= '0;
    end else begin
      if (accept) begin
        hold_full_reg <= 1'b1;
        hold_reg      <= PACKAGE_SIZE'(pack_package(shape_addr, reg_addr, data));
      end else if (load) begin
        hold_full_reg <= 1'b0;
      end
      shift_reg     <= shift_next;
      bit_index_reg <= bit_index_next;
    end
  end

  // Registered line driver and done strobe (glitch-free outputs)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serial_reg  <= 1'b1;
      tx_done_reg <= 1'b0;
    end else begin
      serial_reg  <= serial_next;
      tx_done_reg <= tx_done_next;
    end
  end

endmodule
